// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between the bus sources and the source arbiter.
// The owner-done pulse is named rel because release is a reserved word.
interface bus_source_arbiter_if;
    logic [31:0] req;
    logic        rel;
    logic [31:0] grant;
    logic        busy;
    logic        timeout;

    modport master (
        output req,
        output rel,
        input  grant,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output grant,
        output busy,
        output timeout
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter feeding the 32-to-5 bus-select encoder with a registered
// one-hot (or all-zero) grant, hold timeout and a one-cycle turnaround.
module bus_source_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_source_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t      state, state_nx;
    logic [4:0]  ptr, ptr_nx;
    logic [4:0]  owner, owner_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [31:0] grant_q, grant_nx;
    logic        timeout_q, timeout_nx;

    logic [4:0]  winner;
    logic [4:0]  idx;
    logic        found;
    logic        hold_hit;
    logic        drop;

    // First requester at or after ptr, wrapping mod 32.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            idx = ptr + 5'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign hold_hit = (HOLD_LIM != 8'd0) && (cnt == HOLD_LIM);
    assign drop     = bus.rel || !bus.req[owner];

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        owner_nx   = owner;
        cnt_nx     = cnt;
        grant_nx   = grant_q;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nx = 32'd1 << winner;
                    owner_nx = winner;
                    cnt_nx   = 8'd1;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (drop || hold_hit) begin
                    grant_nx   = '0;
                    ptr_nx     = owner + 5'd1;
                    state_nx   = TURN;
                    // A forced release is flagged only when nothing else ended the grant.
                    timeout_nx = hold_hit && !drop;
                end else if (cnt != 8'hFF) begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            cnt       <= cnt_nx;
            grant_q   <= grant_nx;
            timeout_q <= timeout_nx;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = (state == GRANT);
    assign bus.timeout = timeout_q;

    a_onehot: assert property (@(posedge clock) disable iff (clear) $onehot0(grant_q));
    a_busy:   assert property (@(posedge clock) disable iff (clear) ((grant_q != '0) == (state == GRANT)));
    a_pulse:  assert property (@(posedge clock) disable iff (clear) timeout_q |=> !timeout_q);

endmodule
